// File: rtl/alu_ctl_pkg.sv
// Shared definitions for the stack-CPU ALU sequencer.
// Contents:
//   - 4-bit alu_ctl opcode constants (15 operations plus ILLEGAL)
//   - cmd_kind constants
//   - sequencer FSM state encoding
//   - op-class decode function used for operand routing and legality checks
package alu_ctl_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_NEG     = 4'b0010;
    localparam logic [3:0] ALU_MULT    = 4'b0011;
    localparam logic [3:0] ALU_AND     = 4'b0100;
    localparam logic [3:0] ALU_OR      = 4'b0101;
    localparam logic [3:0] ALU_XOR     = 4'b0110;
    localparam logic [3:0] ALU_NOT     = 4'b0111;
    localparam logic [3:0] ALU_EQ      = 4'b1000;
    localparam logic [3:0] ALU_GT      = 4'b1001;
    localparam logic [3:0] ALU_LEQ     = 4'b1010;
    localparam logic [3:0] ALU_NEGI    = 4'b1011;
    localparam logic [3:0] ALU_NOTI    = 4'b1100;
    localparam logic [3:0] ALU_BZ      = 4'b1101;
    localparam logic [3:0] ALU_BNZ     = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [1:0] KIND_ALU   = 2'b00;
    localparam logic [1:0] KIND_PUSH  = 2'b01;
    localparam logic [1:0] KIND_POP   = 2'b10;
    localparam logic [1:0] KIND_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // BIN: NOS op TOS, pops two and pushes one.
    // UN1: TOS on operand1.  UN2: TOS on operand2.  BR: TOS on operand2, pops one.
    typedef enum logic [2:0] {
        CLS_BIN,
        CLS_UN1,
        CLS_UN2,
        CLS_BR,
        CLS_ILL
    } op_class_t;

    function automatic op_class_t decode_op(input logic [3:0] op);
        op_class_t cls;
        cls = CLS_ILL;
        case (op)
            ALU_ADD, ALU_SUB, ALU_MULT, ALU_AND, ALU_OR,
            ALU_XOR, ALU_EQ, ALU_GT, ALU_LEQ:  cls = CLS_BIN;
            ALU_NEG, ALU_NOT:                  cls = CLS_UN1;
            ALU_NEGI, ALU_NOTI:                cls = CLS_UN2;
            ALU_BZ, ALU_BNZ:                   cls = CLS_BR;
            ALU_ILLEGAL:                       cls = CLS_ILL;
            default:                           cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_stack_seq_op_stack.sv
// op_stack: operand stack storage for alu_stack_seq.
// DEPTH x DBITS register array, one synchronous write port and two
// asynchronous read ports (top-of-stack and next-on-stack). Data is not reset.
// Ports:
//   clk                    clock
//   we, waddr, wdata       write port
//   tos_addr, nos_addr     read addresses
//   tos, nos               read data
module op_stack #(
    parameter int DBITS = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic [AW-1:0]    tos_addr,
    input  logic [AW-1:0]    nos_addr,
    output logic [DBITS-1:0] tos,
    output logic [DBITS-1:0] nos
);

    logic [DBITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign tos = mem[tos_addr];
    assign nos = mem[nos_addr];

endmodule

// File: rtl/alu_stack_seq.sv
// alu_stack_seq: multi-cycle sequencer around the shared combinational ALU.
// Accepts stack commands, keeps an operand stack, feeds the ALU in EXEC and
// writes the result back, returning one response per command.
// Optional build macro: ALU_OP_COUNT_EN adds op_count (saturating count of
// successful ALU-class commands).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_kind, cmd_op, cmd_imm     command payload
//   alu_op1, alu_op2, alu_ctl     ALU drive (zero outside EXEC)
//   alu_result, alu_branch        ALU return
//   rsp_valid, rsp_data, rsp_branch, rsp_err   one-cycle response
//   depth, empty, full            stack occupancy
//   op_count                      (ALU_OP_COUNT_EN only)
//   state_dbg                     current FSM state
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE outside reset, so exactly one command is in
// flight; the payload need only be stable in the accept cycle.
module alu_stack_seq
    import alu_ctl_pkg::*;
#(
    parameter int DBITS = 32,
    parameter int DEPTH = 16,
    localparam int SP_BITS = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_kind,
    input  logic [3:0]         cmd_op,
    input  logic [DBITS-1:0]   cmd_imm,
    output logic [DBITS-1:0]   alu_op1,
    output logic [DBITS-1:0]   alu_op2,
    output logic [3:0]         alu_ctl,
    input  logic [DBITS-1:0]   alu_result,
    input  logic               alu_branch,
    output logic               rsp_valid,
    output logic [DBITS-1:0]   rsp_data,
    output logic               rsp_branch,
    output logic               rsp_err,
    output logic [SP_BITS-1:0] depth,
    output logic               empty,
    output logic               full,
`ifdef ALU_OP_COUNT_EN
    output logic [31:0]        op_count,
`endif
    output logic [2:0]         state_dbg
);

    localparam int AW = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [SP_BITS-1:0] depth_q, depth_next;
    logic [1:0]         kind_q;
    logic [3:0]         op_q;
    logic [DBITS-1:0]   imm_q, opa_q, opb_q, res_q;
    logic               err_q, br_q, cmd_illegal;
    op_class_t          cls_q;

    logic               we;
    logic [AW-1:0]      waddr, tos_addr, nos_addr;
    logic [DBITS-1:0]   wdata, tos, nos;

    // Low address bits wrap naturally, so depth==DEPTH still points at DEPTH-1.
    assign tos_addr = depth_q[AW-1:0] - AW'(1);
    assign nos_addr = depth_q[AW-1:0] - AW'(2);
    assign cls_q    = decode_op(op_q);

    op_stack #(.DBITS(DBITS), .DEPTH(DEPTH)) u_stack (
        .clk      (clk),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .tos_addr (tos_addr),
        .nos_addr (nos_addr),
        .tos      (tos),
        .nos      (nos)
    );

    // Rejects anything that would underflow/overflow the stack.
    always_comb begin
        cmd_illegal = 1'b0;
        case (cmd_kind)
            KIND_ALU: begin
                case (decode_op(cmd_op))
                    CLS_BIN:                  cmd_illegal = (depth_q < SP_BITS'(2));
                    CLS_UN1, CLS_UN2, CLS_BR: cmd_illegal = (depth_q == '0);
                    default:                  cmd_illegal = 1'b1;
                endcase
            end
            KIND_PUSH: cmd_illegal = (depth_q == SP_BITS'(DEPTH));
            KIND_POP:  cmd_illegal = (depth_q == '0);
            default:   cmd_illegal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal)                state_d = ST_DONE;
                    else if (cmd_kind == KIND_ALU)  state_d = ST_LOAD_A;
                    else                            state_d = ST_WRITE;
                end
            end
            ST_LOAD_A: state_d = (cls_q == CLS_BIN) ? ST_LOAD_B : ST_EXEC;
            ST_LOAD_B: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Stack write-back, only effective in WRITE.
    always_comb begin
        we         = 1'b0;
        waddr      = depth_q[AW-1:0];
        wdata      = imm_q;
        depth_next = depth_q;
        case (kind_q)
            KIND_PUSH: begin
                we         = 1'b1;
                depth_next = depth_q + SP_BITS'(1);
            end
            KIND_POP:   depth_next = depth_q - SP_BITS'(1);
            KIND_CLEAR: depth_next = '0;
            default: begin
                case (cls_q)
                    CLS_BIN: begin
                        we         = 1'b1;
                        waddr      = nos_addr;
                        wdata      = res_q;
                        depth_next = depth_q - SP_BITS'(1);
                    end
                    CLS_UN1, CLS_UN2: begin
                        we    = 1'b1;
                        waddr = tos_addr;
                        wdata = res_q;
                    end
                    CLS_BR:  depth_next = depth_q - SP_BITS'(1);
                    default: ;
                endcase
            end
        endcase
        if (state_q != ST_WRITE) begin
            we         = 1'b0;
            depth_next = depth_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_next;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        kind_q <= cmd_kind;
                        op_q   <= cmd_op;
                        imm_q  <= cmd_imm;
                        err_q  <= cmd_illegal;
                    end
                end
                ST_LOAD_A: opa_q <= tos;
                ST_LOAD_B: opb_q <= nos;
                ST_EXEC: begin
                    res_q <= alu_result;
                    br_q  <= alu_branch;
                end
                default: ;
            endcase
        end
    end

    // opa holds TOS, opb holds NOS.
    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        alu_ctl = '0;
        if (state_q == ST_EXEC) begin
            alu_ctl = op_q;
            case (cls_q)
                CLS_BIN: begin
                    alu_op1 = opb_q;
                    alu_op2 = opa_q;
                end
                CLS_UN1:         alu_op1 = opa_q;
                CLS_UN2, CLS_BR: alu_op2 = opa_q;
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE) && !reset;
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_err    = rsp_valid && err_q;
    assign rsp_branch = rsp_valid && !err_q && (kind_q == KIND_ALU) && (cls_q == CLS_BR) && br_q;
    assign rsp_data   = (rsp_valid && (depth_q != '0)) ? tos : '0;
    assign depth      = depth_q;
    assign empty      = (depth_q == '0);
    assign full       = (depth_q == SP_BITS'(DEPTH));
    assign state_dbg  = state_q;

`ifdef ALU_OP_COUNT_EN
    logic [31:0] op_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
        end else if (rsp_valid && !err_q && (kind_q == KIND_ALU) && (op_count_q != 32'hFFFF_FFFF)) begin
            op_count_q <= op_count_q + 32'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_stack_seq.sv
module tb_alu_stack_seq;

  localparam int SP_BITS = 5;

  logic               clk, reset, cmd_valid, cmd_ready;
  logic [1:0]         cmd_kind;
  logic [3:0]         cmd_op, alu_ctl;
  logic [31:0]        cmd_imm, alu_op1, alu_op2, alu_result, rsp_data;
  logic               alu_branch, rsp_valid, rsp_branch, rsp_err, empty, full;
  logic [SP_BITS-1:0] depth;
  logic [2:0]         state_dbg;
`ifdef ALU_OP_COUNT_EN
  logic [31:0]        op_count;
`endif

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;

  // expected stack contents, index $ is top of stack
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  op;
    logic [31:0] imm;
    int          lat;
    logic        err;
    logic [31:0] data;
    logic        br;
    int          dep;
    logic        chk;
    logic [31:0] op1;
    logic [31:0] op2;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        br;
    logic        err;
    int          dep;
    logic        emp;
    logic        ful;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [3:0]  xc;
    logic        quiet;
  } obs_t;

  vec_t vecs[23];

  alu_stack_seq dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_op     (cmd_op),
    .cmd_imm    (cmd_imm),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctl    (alu_ctl),
    .alu_result (alu_result),
    .alu_branch (alu_branch),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_branch (rsp_branch),
    .rsp_err    (rsp_err),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
`ifdef ALU_OP_COUNT_EN
    .op_count   (op_count),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // combinational ALU model standing in for the real ALU
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return -a;
      4'd3:    return a * b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return {31'd0, a == b};
      4'd9:    return {31'd0, a > b};
      4'd10:   return {31'd0, a <= b};
      4'd11:   return -b;
      4'd12:   return ~b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op1, alu_op2, alu_ctl);
  assign alu_branch = (alu_ctl == 4'd13) ? (alu_op2 == 32'd0) :
                      (alu_ctl == 4'd14) ? (alu_op2 != 32'd0) : 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] kind, input logic [3:0] op, input logic [31:0] imm,
                              input int lat, input logic err, input logic [31:0] data, input logic br,
                              input int dep, input logic chk, input logic [31:0] op1, input logic [31:0] op2);
    vec_t v;
    v.kind = kind; v.op = op; v.imm = imm; v.lat = lat; v.err = err; v.data = data;
    v.br = br; v.dep = dep; v.chk = chk; v.op1 = op1; v.op2 = op2;
    return v;
  endfunction

  // reference model: applies the command to exp_q and returns the expected response
  task automatic ref_step(input logic [1:0] kind, input logic [3:0] op, input logic [31:0] imm, output vec_t e);
    int n;
    logic [31:0] t, s;
    n = exp_q.size();
    e = mk(kind, op, imm, 2, 1'b0, 32'd0, 1'b0, 0, 1'b0, 32'd0, 32'd0);
    case (kind)
      2'b01: if (n == 16) e.err = 1'b1; else exp_q.push_back(imm);
      2'b10: if (n == 0) e.err = 1'b1; else void'(exp_q.pop_back());
      2'b11: exp_q.delete();
      default: begin
        if (op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10}) begin
          if (n < 2) e.err = 1'b1;
          else begin
            t = exp_q.pop_back();
            s = exp_q.pop_back();
            exp_q.push_back(alu_fn(s, t, op));
            e.lat = 5; e.chk = 1'b1; e.op1 = s; e.op2 = t;
          end
        end else if (op inside {4'd2, 4'd7, 4'd11, 4'd12}) begin
          if (n < 1) e.err = 1'b1;
          else begin
            t = exp_q[n-1];
            e.lat = 4; e.chk = 1'b1;
            if (op inside {4'd2, 4'd7}) begin
              e.op1 = t;
              exp_q[n-1] = alu_fn(t, 32'd0, op);
            end else begin
              e.op2 = t;
              exp_q[n-1] = alu_fn(32'd0, t, op);
            end
          end
        end else if (op inside {4'd13, 4'd14}) begin
          if (n < 1) e.err = 1'b1;
          else begin
            t = exp_q.pop_back();
            e.lat = 4; e.chk = 1'b1; e.op2 = t;
            e.br = (op == 4'd13) ? (t == 32'd0) : (t != 32'd0);
          end
        end else begin
          e.err = 1'b1;
        end
        if (!e.err) exp_ops++;
      end
    endcase
    if (e.err) e.lat = 1;
    e.dep  = exp_q.size();
    e.data = (exp_q.size() != 0) ? exp_q[$] : 32'd0;
  endtask

  // driver: issues one command and watches up to 10 cycles for the response
  task automatic run_cmd(input logic [1:0] kind, input logic [3:0] op, input logic [31:0] imm,
                         input int exec_n, output obs_t o);
    int guard;
    o.lat = 99; o.data = 32'd0; o.br = 1'b0; o.err = 1'b0; o.dep = 0; o.emp = 1'b0; o.ful = 1'b0;
    o.x1 = 32'd0; o.x2 = 32'd0; o.xc = 4'd0; o.quiet = 1'b1;
    @(posedge clk); #1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_kind = kind; cmd_op = op; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_kind = $urandom_range(0, 3); cmd_op = $urandom_range(0, 15); cmd_imm = $urandom;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == exec_n) begin
        o.x1 = alu_op1; o.x2 = alu_op2; o.xc = alu_ctl;
      end else if (alu_op1 != 32'd0 || alu_op2 != 32'd0 || alu_ctl != 4'd0) begin
        o.quiet = 1'b0;
      end
      if (rsp_valid) begin
        o.lat = n; o.data = rsp_data; o.br = rsp_branch; o.err = rsp_err;
        o.dep = int'(depth); o.emp = empty; o.ful = full;
        break;
      end
    end
  endtask

  // scoreboard compare of one response
  task automatic compare(input string tag, input obs_t o, input vec_t e);
    check({tag, ".latency"}, 64'(o.lat), 64'(e.lat));
    check({tag, ".err"},     {63'd0, o.err}, {63'd0, e.err});
    check({tag, ".data"},    {32'd0, o.data}, {32'd0, e.data});
    check({tag, ".branch"},  {63'd0, o.br}, {63'd0, e.br});
    check({tag, ".depth"},   64'(o.dep), 64'(e.dep));
    check({tag, ".empty"},   {63'd0, o.emp}, {63'd0, e.dep == 0});
    check({tag, ".full"},    {63'd0, o.ful}, {63'd0, e.dep == 16});
    check({tag, ".alu_idle_zero"}, {63'd0, o.quiet}, 64'd1);
    if (e.chk) begin
      check({tag, ".alu_op1"}, {32'd0, o.x1}, {32'd0, e.op1});
      check({tag, ".alu_op2"}, {32'd0, o.x2}, {32'd0, e.op2});
      check({tag, ".alu_ctl"}, {60'd0, o.xc}, {60'd0, e.op});
    end
  endtask

  task automatic model_cmd(input string tag, input logic [1:0] kind, input logic [3:0] op, input logic [31:0] imm);
    vec_t e;
    obs_t o;
    ref_step(kind, op, imm, e);
    run_cmd(kind, op, imm, e.chk ? e.lat - 2 : 0, o);
    compare(tag, o, e);
  endtask

  initial begin
    vec_t e;
    obs_t o;
    logic seen;

    // directed vectors: kind, op, imm, lat, err, data, br, depth, chk, op1, op2
    vecs[0]  = mk(2'b01, 4'd0,  32'h1000, 2, 0, 32'h1000,     0, 1, 0, 0, 0);
    vecs[1]  = mk(2'b01, 4'd0,  32'h1,    2, 0, 32'h1,        0, 2, 0, 0, 0);
    vecs[2]  = mk(2'b00, 4'd1,  32'h0,    5, 0, 32'h0FFF,     0, 1, 1, 32'h1000, 32'h1);
    vecs[3]  = mk(2'b01, 4'd0,  32'h1000, 2, 0, 32'h1000,     0, 2, 0, 0, 0);
    vecs[4]  = mk(2'b00, 4'd2,  32'h0,    4, 0, 32'hFFFFF000, 0, 2, 1, 32'h1000, 32'h0);
    vecs[5]  = mk(2'b11, 4'd0,  32'h0,    2, 0, 32'h0,        0, 0, 0, 0, 0);
    vecs[6]  = mk(2'b01, 4'd0,  32'h0,    2, 0, 32'h0,        0, 1, 0, 0, 0);
    vecs[7]  = mk(2'b00, 4'd13, 32'h0,    4, 0, 32'h0,        1, 0, 1, 32'h0, 32'h0);
    vecs[8]  = mk(2'b01, 4'd0,  32'h5,    2, 0, 32'h5,        0, 1, 0, 0, 0);
    vecs[9]  = mk(2'b00, 4'd13, 32'h0,    4, 0, 32'h0,        0, 0, 1, 32'h0, 32'h5);
    vecs[10] = mk(2'b00, 4'd0,  32'h0,    1, 1, 32'h0,        0, 0, 0, 0, 0);
    vecs[11] = mk(2'b10, 4'd0,  32'h0,    1, 1, 32'h0,        0, 0, 0, 0, 0);
    vecs[12] = mk(2'b00, 4'd7,  32'h0,    1, 1, 32'h0,        0, 0, 0, 0, 0);
    vecs[13] = mk(2'b01, 4'd0,  32'h9,    2, 0, 32'h9,        0, 1, 0, 0, 0);
    vecs[14] = mk(2'b00, 4'd3,  32'h0,    1, 1, 32'h9,        0, 1, 0, 0, 0);
    vecs[15] = mk(2'b00, 4'd14, 32'h0,    4, 0, 32'h0,        1, 0, 1, 32'h0, 32'h9);
    vecs[16] = mk(2'b01, 4'd0,  32'h7,    2, 0, 32'h7,        0, 1, 0, 0, 0);
    vecs[17] = mk(2'b01, 4'd0,  32'h3,    2, 0, 32'h3,        0, 2, 0, 0, 0);
    vecs[18] = mk(2'b01, 4'd0,  32'h20,   2, 0, 32'h20,       0, 3, 0, 0, 0);
    vecs[19] = mk(2'b00, 4'd15, 32'h0,    1, 1, 32'h20,       0, 3, 0, 0, 0);
    vecs[20] = mk(2'b00, 4'd9,  32'h0,    5, 0, 32'h0,        0, 2, 1, 32'h3, 32'h20);
    vecs[21] = mk(2'b00, 4'd12, 32'h0,    4, 0, 32'hFFFFFFFF, 0, 2, 1, 32'h0, 32'h0);
    vecs[22] = mk(2'b11, 4'd0,  32'h0,    2, 0, 32'h0,        0, 0, 0, 0, 0);

    reset = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_op = 4'd0; cmd_imm = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst.rsp_valid",  {63'd0, rsp_valid}, 64'd0);
    check("rst.rsp_data",   {32'd0, rsp_data}, 64'd0);
    check("rst.rsp_branch", {63'd0, rsp_branch}, 64'd0);
    check("rst.rsp_err",    {63'd0, rsp_err}, 64'd0);
    check("rst.alu_op1",    {32'd0, alu_op1}, 64'd0);
    check("rst.alu_op2",    {32'd0, alu_op2}, 64'd0);
    check("rst.alu_ctl",    {60'd0, alu_ctl}, 64'd0);
    check("rst.depth",      64'(depth), 64'd0);
    check("rst.empty",      {63'd0, empty}, 64'd1);
    check("rst.full",       {63'd0, full}, 64'd0);
    check("rst.cmd_ready",  {63'd0, cmd_ready}, 64'd1);

    // table-driven directed vectors; model kept in step for later phases
    for (int i = 0; i < 23; i++) begin
      ref_step(vecs[i].kind, vecs[i].op, vecs[i].imm, e);
      run_cmd(vecs[i].kind, vecs[i].op, vecs[i].imm, vecs[i].chk ? vecs[i].lat - 2 : 0, o);
      compare($sformatf("vec%0d", i), o, vecs[i]);
    end

    // fill to capacity, then overflow
    for (int i = 0; i < 16; i++) begin
      model_cmd($sformatf("fill%0d", i), 2'b01, 4'd0, 32'(i * 17 + 7));
    end
    ref_step(2'b01, 4'd0, 32'hDEAD, e);
    run_cmd(2'b01, 4'd0, 32'hDEAD, 0, o);
    compare("overflow", o, e);
    check("overflow.full_lit", {63'd0, o.ful}, 64'd1);
    check("overflow.tos_lit",  {32'd0, o.data}, 64'h106);

    // reset while a BIN op sits in EXEC
    model_cmd("pre_rst_clear", 2'b11, 4'd0, 32'd0);
    model_cmd("pre_rst_push7", 2'b01, 4'd0, 32'd7);
    model_cmd("pre_rst_push3", 2'b01, 4'd0, 32'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_op = 4'd9; cmd_imm = 32'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.exec_ctl", {60'd0, alu_ctl}, 64'd9);
    check("midrst.exec_op1", {32'd0, alu_op1}, 64'd7);
    check("midrst.exec_op2", {32'd0, alu_op2}, 64'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst.depth",     64'(depth), 64'd0);
    check("midrst.cmd_ready", {63'd0, cmd_ready}, 64'd1);
    seen = rsp_valid;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("midrst.no_rsp", {63'd0, seen}, 64'd0);
    exp_q.delete();
    exp_ops = 0;

    // randomized commands against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] k;
      logic [31:0] imm;
      r = $urandom_range(0, 19);
      if (r < 8)       k = 2'b00;
      else if (r < 14) k = 2'b01;
      else if (r < 18) k = 2'b10;
      else             k = 2'b11;
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      model_cmd($sformatf("rnd%0d", i), k, 4'($urandom_range(0, 15)), imm);
    end

`ifdef ALU_OP_COUNT_EN
    @(negedge clk);
    check("op_count", {32'd0, op_count}, 64'(exp_ops));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
